// File: rtl/vga_timing_monitor.sv
// Receive-side VGA sync checker: rebuilds column/row, measures line, width and frame
// timing, and runs a lock FSM that flags when a locked stream drifts off the expected mode.
module vga_timing_monitor #(
    parameter int X_WIDTH         = 10,
    parameter int Y_WIDTH         = 10,
    parameter int CNT_WIDTH       = 16,
    parameter int CLKS_PER_PIXEL  = 2,
    parameter int EXP_LINE_CLKS   = 1600,
    parameter int EXP_ACTIVE_COLS = 640,
    parameter int LOCK_LINES      = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iHSync,
    input  logic                 iVSync,
    input  logic                 iDisplay,
    output logic [X_WIDTH-1:0]   oCol,
    output logic [Y_WIDTH-1:0]   oRow,
    output logic [CNT_WIDTH-1:0] oLineLength,
    output logic [X_WIDTH-1:0]   oActiveCols,
    output logic [Y_WIDTH-1:0]   oLinesPerFrame,
    output logic                 oFrameStart,
    output logic                 oLocked,
    output logic                 oTimingError
);

    localparam int DIV_W  = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam int LOCK_W = $clog2(LOCK_LINES + 1);

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] CHECKING = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(2 * EXP_LINE_CLKS);
    localparam logic [CNT_WIDTH-1:0] LINE_EXP    = CNT_WIDTH'(EXP_LINE_CLKS);
    localparam logic [X_WIDTH-1:0]   COLS_EXP    = X_WIDTH'(EXP_ACTIVE_COLS);
    localparam logic [DIV_W-1:0]     PIX_LAST    = DIV_W'(CLKS_PER_PIXEL - 1);
    localparam logic [LOCK_W-1:0]    LOCK_TARGET = LOCK_W'(LOCK_LINES);

    logic                 hsR, vsR, deR, hsP, vsP, deP;
    logic                 hsFall, vsFall, deRise, deFall;
    logic [CNT_WIDTH-1:0] lineCnt, lineLen;
    logic                 haveRef, timeout, goodLine, pixDone;
    logic [DIV_W-1:0]     divCnt;
    logic [Y_WIDTH-1:0]   lineTally;
    logic [1:0]           state, stateNext;
    logic [LOCK_W-1:0]    goodCount, countNext;
    logic                 errNext;

    // Idle levels on reset keep the first post-reset cycle free of phantom edges.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hsR <= 1'b1;
            vsR <= 1'b1;
            deR <= 1'b0;
            hsP <= 1'b1;
            vsP <= 1'b1;
            deP <= 1'b0;
        end else begin
            hsR <= iHSync;
            vsR <= iVSync;
            deR <= iDisplay;
            hsP <= hsR;
            vsP <= vsR;
            deP <= deR;
        end
    end

    assign hsFall   = hsP & ~hsR;
    assign vsFall   = vsP & ~vsR;
    assign deRise   = ~deP & deR;
    assign deFall   = deP & ~deR;
    assign lineLen  = (lineCnt == '1) ? lineCnt : lineCnt + CNT_WIDTH'(1);
    assign timeout  = ~hsFall & (lineCnt == TIMEOUT_CNT);
    assign pixDone  = (divCnt == PIX_LAST);
    assign goodLine = (lineLen == LINE_EXP) && (oActiveCols == COLS_EXP);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            lineCnt     <= '0;
            haveRef     <= 1'b0;
            oLineLength <= '0;
        end else if (hsFall) begin
            lineCnt <= '0;
            haveRef <= 1'b1;
            if (haveRef) oLineLength <= lineLen;
        end else begin
            if (lineCnt != '1) lineCnt <= lineCnt + CNT_WIDTH'(1);
            if (timeout) haveRef <= 1'b0;
        end
    end

    // The falling-edge clock still finishes a pixel whose divider is on its last count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oCol        <= '0;
            divCnt      <= '0;
            oActiveCols <= '0;
        end else begin
            if (deRise) begin
                oCol   <= '0;
                divCnt <= '0;
            end else if (deR) begin
                if (pixDone) begin
                    divCnt <= '0;
                    oCol   <= oCol + X_WIDTH'(1);
                end else begin
                    divCnt <= divCnt + DIV_W'(1);
                end
            end
            if (deFall) oActiveCols <= oCol + X_WIDTH'(pixDone);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oRow           <= '0;
            lineTally      <= '0;
            oLinesPerFrame <= '0;
            oFrameStart    <= 1'b0;
        end else if (vsFall) begin
            oRow           <= '0;
            oFrameStart    <= 1'b1;
            oLinesPerFrame <= lineTally + Y_WIDTH'(hsFall);
            lineTally      <= '0;
        end else begin
            oFrameStart <= 1'b0;
            if (deFall) oRow <= oRow + Y_WIDTH'(1);
            if (hsFall) lineTally <= lineTally + Y_WIDTH'(1);
        end
    end

    // Only a loss of lock raises the error pulse; failures while still acquiring just restart.
    always_comb begin
        stateNext = state;
        countNext = goodCount;
        errNext   = 1'b0;
        if (hsFall && haveRef) begin
            if (goodLine) begin
                if (state != LOCKED) begin
                    countNext = (state == CHECKING) ? goodCount + LOCK_W'(1) : LOCK_W'(1);
                    stateNext = (countNext >= LOCK_TARGET) ? LOCKED : CHECKING;
                end
            end else begin
                errNext   = (state == LOCKED);
                stateNext = UNLOCKED;
                countNext = '0;
            end
        end else if (timeout) begin
            errNext   = (state == LOCKED);
            stateNext = UNLOCKED;
            countNext = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= UNLOCKED;
            goodCount    <= '0;
            oLocked      <= 1'b0;
            oTimingError <= 1'b0;
        end else begin
            state        <= stateNext;
            goodCount    <= countNext;
            oLocked      <= (stateNext == LOCKED);
            oTimingError <= errNext;
        end
    end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor: an event-time reference model queues the
// expected outputs for every cycle and a separate monitor compares them against the DUT.
module tb_vga_timing_monitor;

    localparam int CPP   = 2;
    localparam int EXPL  = 1600;
    localparam int EXPC  = 640;
    localparam int LOCKN = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iHSync = 1'b1;
    logic        iVSync = 1'b1;
    logic        iDisplay = 1'b0;
    logic [9:0]  oCol, oRow, oActiveCols, oLinesPerFrame;
    logic [15:0] oLineLength;
    logic        oFrameStart, oLocked, oTimingError;

    vga_timing_monitor #(
        .X_WIDTH(10), .Y_WIDTH(10), .CNT_WIDTH(16), .CLKS_PER_PIXEL(CPP),
        .EXP_LINE_CLKS(EXPL), .EXP_ACTIVE_COLS(EXPC), .LOCK_LINES(LOCKN)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iHSync(iHSync), .iVSync(iVSync), .iDisplay(iDisplay),
        .oCol(oCol), .oRow(oRow), .oLineLength(oLineLength), .oActiveCols(oActiveCols),
        .oLinesPerFrame(oLinesPerFrame), .oFrameStart(oFrameStart), .oLocked(oLocked),
        .oTimingError(oTimingError)
    );

    always #5 Clock = ~Clock;

    int cycleNo = 0;
    always @(posedge Clock) cycleNo <= cycleNo + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int due;
        int len;
        int cols;
        int lpf;
        int row;
        int col;
        bit locked;
        bit fs;
        bit err;
    } exp_t;

    exp_t q[$];
    exp_t monE;

    // Reference state is kept as event times: last line start, last display rise, run of good lines.
    bit mPrevH = 1, mPrevV = 1, mPrevD = 0, mHaveRef = 0, mLocked = 0;
    int mCntBase = 0, mRun = 0, mRiseT = 0;
    int mLen = 0, mCols = 0, mLpf = 0, mRow = 0, mCol = 0, mTally = 0;

    task automatic modelStep(input int n, input bit rst, input bit h, input bit v, input bit d);
        exp_t e;
        bit hf, vf, dr, df, good, errP, fsP;
        int elapsed, len;
        e = '{default: 0};
        if (rst) begin
            mPrevH = 1; mPrevV = 1; mPrevD = 0; mHaveRef = 0; mLocked = 0;
            mCntBase = n - 1; mRun = 0; mRiseT = 0;
            mLen = 0; mCols = 0; mLpf = 0; mRow = 0; mCol = 0; mTally = 0;
            e.due = n + 1;
            if (q.size() > 0 && q[q.size()-1].due == n + 1) q[q.size()-1] = e;
            else q.push_back(e);
            e.due = n + 2;
            q.push_back(e);
            return;
        end
        hf = mPrevH & ~h;
        vf = mPrevV & ~v;
        dr = ~mPrevD & d;
        df = mPrevD & ~d;
        errP = 0;
        fsP = 0;
        elapsed = n - mCntBase - 1;
        if (elapsed > 65535) elapsed = 65535;
        if (hf) begin
            if (mHaveRef) begin
                len = (elapsed == 65535) ? 65535 : elapsed + 1;
                mLen = len;
                good = (len == EXPL) && (mCols == EXPC);
                if (good) begin
                    if (!mLocked) begin
                        mRun++;
                        if (mRun >= LOCKN) mLocked = 1;
                    end
                end else begin
                    errP = mLocked;
                    mLocked = 0;
                    mRun = 0;
                end
            end
            mHaveRef = 1;
            mCntBase = n;
        end else if (elapsed == 2 * EXPL) begin
            errP = mLocked;
            mLocked = 0;
            mRun = 0;
            mHaveRef = 0;
        end
        if (dr) begin
            mRiseT = n;
            mCol = 0;
        end else if (d) begin
            mCol = ((n - mRiseT) / CPP) % 1024;
        end
        if (df) begin
            mCols = ((n - mRiseT) / CPP) % 1024;
            mRow = (mRow + 1) % 1024;
        end
        if (vf) begin
            fsP = 1;
            mLpf = (mTally + int'(hf)) % 1024;
            mTally = 0;
            mRow = 0;
        end else if (hf) begin
            mTally = (mTally + 1) % 1024;
        end
        mPrevH = h;
        mPrevV = v;
        mPrevD = d;
        e.due = n + 2;
        e.len = mLen;
        e.cols = mCols;
        e.lpf = mLpf;
        e.row = mRow;
        e.col = mCol;
        e.locked = mLocked;
        e.fs = fsP;
        e.err = errP;
        q.push_back(e);
    endtask

    task automatic driveCycle(input bit rst, input bit h, input bit v, input bit d);
        @(posedge Clock);
        #1;
        Reset = rst;
        iHSync = h;
        iVSync = v;
        iDisplay = d;
        modelStep(cycleNo, rst, h, v, d);
    endtask

    task automatic applyStimulus(input int len, input int deLen, input int vsOff,
                                 input bit hsOn, input int rstAt, input int rstLen);
        int hsw;
        int deStart;
        hsw = int'($urandom_range(96, 180));
        deStart = int'($urandom_range(200, 240));
        for (int c = 0; c < len; c++) begin
            bit h, v, d, r;
            h = !(hsOn && c < hsw);
            v = !(vsOff >= 0 && c >= vsOff);
            d = (c >= deStart && c < deStart + deLen);
            r = (rstAt >= 0 && c >= rstAt && c < rstAt + rstLen);
            driveCycle(r, h, v, d);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if (int'(oLineLength) != e.len || int'(oActiveCols) != e.cols ||
            int'(oLinesPerFrame) != e.lpf || int'(oRow) != e.row || int'(oCol) != e.col ||
            oLocked !== e.locked || oFrameStart !== e.fs || oTimingError !== e.err) begin
            bad++;
            $display("[TB] FAIL cycle %0d outputs: got len=%0d cols=%0d lpf=%0d row=%0d col=%0d lock=%0b fs=%0b err=%0b, want len=%0d cols=%0d lpf=%0d row=%0d col=%0d lock=%0b fs=%0b err=%0b",
                     cycleNo, oLineLength, oActiveCols, oLinesPerFrame, oRow, oCol, oLocked,
                     oFrameStart, oTimingError, e.len, e.cols, e.lpf, e.row, e.col, e.locked,
                     e.fs, e.err);
        end
    endtask

    always @(negedge Clock) begin
        if (q.size() > 0) begin
            if (q[0].due == cycleNo) begin
                monE = q.pop_front();
                checkOutput(monE);
            end else if (q[0].due < cycleNo) begin
                monE = q.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL scoreboard order: entry due %0d still queued at cycle %0d", monE.due, cycleNo);
            end
        end
    end

    initial begin
        #1200000;
        $display("[TB] FAIL watchdog: run still active at cycle %0d, required finish before it", cycleNo);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len, deLen, vsOff;
        repeat (4) driveCycle(1'b1, 1'b1, 1'b1, 1'b0);

        $display("[TB] nominal frames");
        for (int i = 0; i < 7; i++) applyStimulus(EXPL, 1280, (i % 5 == 0) ? 50 : -1, 1'b1, -1, 0);

        $display("[TB] short line then relock");
        applyStimulus(1598, 1280, -1, 1'b1, -1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(EXPL, 1280, -1, 1'b1, -1, 0);

        $display("[TB] lost sync then relock");
        applyStimulus(3400, 1280, -1, 1'b0, -1, 0);
        for (int i = 0; i < 6; i++) applyStimulus(EXPL, 1280, -1, 1'b1, -1, 0);

        $display("[TB] simultaneous HSync/VSync fall");
        applyStimulus(EXPL, 1280, 50, 1'b1, -1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(EXPL, 1280, -1, 1'b1, -1, 0);
        applyStimulus(EXPL, 1280, 0, 1'b1, -1, 0);
        applyStimulus(EXPL, 1280, -1, 1'b1, -1, 0);

        $display("[TB] reset mid-line while locked");
        applyStimulus(EXPL, 1280, -1, 1'b1, 700, 3);
        for (int i = 0; i < 6; i++) applyStimulus(EXPL, 1280, -1, 1'b1, -1, 0);

        $display("[TB] narrow active window");
        applyStimulus(EXPL, 1278, -1, 1'b1, -1, 0);
        applyStimulus(EXPL, 1280, -1, 1'b1, -1, 0);

        $display("[TB] randomized lines");
        for (int i = 0; i < 4; i++) begin
            len = ($urandom_range(0, 3) == 0) ? EXPL - 3 + int'($urandom_range(0, 6)) : EXPL;
            deLen = ($urandom_range(0, 3) == 0) ? 1276 + int'($urandom_range(0, 8)) : 1280;
            vsOff = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1000)) : -1;
            applyStimulus(len, deLen, vsOff, 1'b1, -1, 0);
        end

        repeat (4) @(posedge Clock);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d queued entries, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
